// File: rtl/subtractor_unit.sv
// Registered two-operand subtractor with ALU status flags (borrow, zero, negative, overflow).
// One-cycle latency; outputs hold their last value whenever in_valid is low.
module subtractor_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             out_valid,
   output logic             borrow,
   output logic             zero,
   output logic             negative,
   output logic             overflow
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH:0]   diff_full;
   logic [WIDTH-1:0] diff_low;

   logic [WIDTH-1:0] y_reg, y_next;
   logic             valid_reg, valid_next;
   logic             borrow_reg, borrow_next;
   logic             zero_reg, zero_next;
   logic             negative_reg, negative_next;
   logic             overflow_reg, overflow_next;

   // Zero-extended subtraction: bit WIDTH of the result is the unsigned borrow.
   assign diff_full = {1'b0, a} - {1'b0, b};
   assign diff_low  = diff_full[WIDTH-1:0];

   always_comb begin
      y_next        = y_reg;
      valid_next    = 1'b0;
      borrow_next   = borrow_reg;
      zero_next     = zero_reg;
      negative_next = negative_reg;
      overflow_next = overflow_reg;
      if (in_valid) begin
         y_next        = diff_low;
         valid_next    = 1'b1;
         borrow_next   = diff_full[WIDTH];
         zero_next     = (diff_low == '0);
         negative_next = diff_low[MSB];
         // Signed overflow only possible when operand signs differ.
         overflow_next = (a[MSB] != b[MSB]) && (diff_low[MSB] != a[MSB]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_reg        <= '0;
         valid_reg    <= 1'b0;
         borrow_reg   <= 1'b0;
         zero_reg     <= 1'b0;
         negative_reg <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         y_reg        <= y_next;
         valid_reg    <= valid_next;
         borrow_reg   <= borrow_next;
         zero_reg     <= zero_next;
         negative_reg <= negative_next;
         overflow_reg <= overflow_next;
      end
   end

   assign y         = y_reg;
   assign out_valid = valid_reg;
   assign borrow    = borrow_reg;
   assign zero      = zero_reg;
   assign negative  = negative_reg;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_subtractor_unit.sv
// Directed plus randomized checks of subtractor_unit against an integer-arithmetic model.
module tb_subtractor_unit;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] y;
   logic             out_valid;
   logic             borrow;
   logic             zero;
   logic             negative;
   logic             overflow;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] exp_y;
   logic             exp_valid, exp_borrow, exp_zero, exp_neg, exp_ovf;

   subtractor_unit #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .y         (y),
      .out_valid (out_valid),
      .borrow    (borrow),
      .zero      (zero),
      .negative  (negative),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      exp_y = '0; exp_valid = 1'b0; exp_borrow = 1'b0;
      exp_zero = 1'b0; exp_neg = 1'b0; exp_ovf = 1'b0;
   endtask

   // Plain integer arithmetic on unsigned and signed interpretations.
   task automatic model_update(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_val, input logic v);
      int ud;
      int sd;
      exp_valid = v;
      if (v) begin
         ud = int'(ta) - int'(tb_val);
         sd = int'($signed(ta)) - int'($signed(tb_val));
         exp_y      = ud[WIDTH-1:0];
         exp_borrow = (ud < 0);
         exp_zero   = (exp_y == 0);
         exp_neg    = exp_y[WIDTH-1];
         exp_ovf    = (sd > 32767) || (sd < -32768);
      end
   endtask

   task automatic check_all(input string tag);
      checks++;
      assert (out_valid === exp_valid) else begin
         failures++;
         $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, exp_valid);
      end
      checks++;
      assert (y === exp_y) else begin
         failures++;
         $error("FAIL %s y: got %h expected %h", tag, y, exp_y);
      end
      checks++;
      assert (borrow === exp_borrow) else begin
         failures++;
         $error("FAIL %s borrow: got %b expected %b", tag, borrow, exp_borrow);
      end
      checks++;
      assert (zero === exp_zero) else begin
         failures++;
         $error("FAIL %s zero: got %b expected %b", tag, zero, exp_zero);
      end
      checks++;
      assert (negative === exp_neg) else begin
         failures++;
         $error("FAIL %s negative: got %b expected %b", tag, negative, exp_neg);
      end
      checks++;
      assert (overflow === exp_ovf) else begin
         failures++;
         $error("FAIL %s overflow: got %b expected %b", tag, overflow, exp_ovf);
      end
   endtask

   task automatic step(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_val, input logic v, input string tag);
      @(negedge clk);
      a = ta; b = tb_val; in_valid = v;
      @(posedge clk);
      #1;
      model_update(ta, tb_val, v);
      check_all(tag);
      $display("%s: v=%b a=%h b=%h -> y=%h ov=%b bor=%b z=%b n=%b ovf=%b",
               tag, v, ta, tb_val, y, out_valid, borrow, zero, negative, overflow);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      logic             rv;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
      model_reset();
      #12;
      check_all("reset_init");
      @(negedge clk);
      rst_n = 1'b1;

      step(16'd0,      16'd0,      1'b1, "zero_zero");
      step(16'd2,      16'd1,      1'b1, "two_minus_one");
      step(16'd1000,   16'd333,    1'b1, "k_minus_333");
      step(16'd1,      16'd2,      1'b1, "wrap_small");
      step(16'd250,    16'd1500,   1'b1, "wrap_large");
      step(16'h8000,   16'h0001,   1'b1, "ovf_neg_min");
      step(16'h7FFF,   16'hFFFF,   1'b1, "ovf_pos_max");
      step(16'd5,      16'd3,      1'b1, "hold_load");
      step(16'd9,      16'd9,      1'b0, "hold_idle1");
      step(16'hFFFF,   16'h0000,   1'b0, "hold_idle2");
      step(16'hFFFF,   16'hFFFF,   1'b1, "equal_max");

      // Asynchronous reset asserted between edges while results are streaming.
      step(16'h1234,   16'h0F00,   1'b1, "pre_reset");
      @(negedge clk);
      a = 16'h4000; b = 16'h0001; in_valid = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("reset_async");
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_all("post_reset_idle");
      step(16'h0010,   16'h0020,   1'b1, "post_reset_first");

      for (int i = 0; i < 200; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         case ($urandom_range(0, 7))
            0: ra = rb;
            1: ra = 16'h8000;
            2: rb = 16'h7FFF;
            default: ;
         endcase
         rv = ($urandom_range(0, 3) != 0);
         step(ra, rb, rv, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
